// File: rtl/demux_1to2_16b.sv
// Buffered 1-to-2 valid/ready stream demux with one FIFO per output channel.
// Define DEMUX_CNT_EN to add the per-channel pop counters cnt1/cnt2.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module demux_1to2_16b #(
  parameter int DATA_W = `DATA_BITS,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out2_valid,
  input  logic              out2_ready,
  output logic [DATA_W-1:0] out2_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [15:0]       cnt1,
  output logic [15:0]       cnt2
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem1 [DEPTH];
  logic [DATA_W-1:0] r_mem2 [DEPTH];
  logic [AW-1:0]     r_wr1, r_rd1;
  logic [AW-1:0]     r_wr2, r_rd2;
  logic [AW:0]       r_cnt1, r_cnt2;

  logic w_push1, w_push2;
  logic w_pop1, w_pop2;

  // Ready depends only on registered counts, never on the out readies.
  assign in_ready = !rst &&
    (in_sel ? (r_cnt2 < FULL) : (r_cnt1 < FULL));

  assign w_push1 = in_valid && in_ready && !in_sel;
  assign w_push2 = in_valid && in_ready &&  in_sel;

  assign out1_valid = !rst && (r_cnt1 != '0);
  assign out2_valid = !rst && (r_cnt2 != '0);
  assign w_pop1 = out1_valid && out1_ready;
  assign w_pop2 = out2_valid && out2_ready;

  assign out1_data = out1_valid ? r_mem1[r_rd1] : '0;
  assign out2_data = out2_valid ? r_mem2[r_rd2] : '0;

  always_ff @(posedge clk) begin
    if (w_push1) r_mem1[r_wr1] <= in_data;
    if (w_push2) r_mem2[r_wr2] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr1  <= '0;
      r_rd1  <= '0;
      r_cnt1 <= '0;
      r_wr2  <= '0;
      r_rd2  <= '0;
      r_cnt2 <= '0;
    end else begin
      if (w_push1) r_wr1 <= r_wr1 + 1'b1;
      if (w_pop1)  r_rd1 <= r_rd1 + 1'b1;
      if (w_push2) r_wr2 <= r_wr2 + 1'b1;
      if (w_pop2)  r_rd2 <= r_rd2 + 1'b1;
      unique case ({w_push1, w_pop1})
        2'b10:   r_cnt1 <= r_cnt1 + 1'b1;
        2'b01:   r_cnt1 <= r_cnt1 - 1'b1;
        default: r_cnt1 <= r_cnt1;
      endcase
      unique case ({w_push2, w_pop2})
        2'b10:   r_cnt2 <= r_cnt2 + 1'b1;
        2'b01:   r_cnt2 <= r_cnt2 - 1'b1;
        default: r_cnt2 <= r_cnt2;
      endcase
    end
  end

`ifdef DEMUX_CNT_EN
  logic [15:0] r_pops1, r_pops2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pops1 <= '0;
      r_pops2 <= '0;
    end else begin
      if (w_pop1 && (r_pops1 != 16'hFFFF)) r_pops1 <= r_pops1 + 1'b1;
      if (w_pop2 && (r_pops2 != 16'hFFFF)) r_pops2 <= r_pops2 + 1'b1;
    end
  end

  assign cnt1 = r_pops1;
  assign cnt2 = r_pops2;
`endif

endmodule
